fp32_to_fp9_cvt: RTL and testbench
==================================

Name: fp32_to_fp9_cvt

Overview:
- Streaming converter from IEEE-754 binary32 to the 9-bit vector-ALU float format: sign[8], exp[7:3] (5 bits, bias EXP_BIAS), man[2:0].
- Sits after the vector ALU multiply/accumulate path and re-quantises wide results back to operand width for write-back.
- 2-stage pipeline with valid/ready on both sides and full backpressure.

Parameters:
- EXP_BIAS, 15, FP9 exponent bias.
- MAX_EXP, 30, largest finite FP9 exponent field; 31 is reserved for Inf/NaN.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  converter can accept a word this cycle.
- in_data  in  32  binary32 operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  9  FP9 result.
- out_flags  out  3  {overflow_sat, underflow_to_zero, inexact}, aligned with out_data.

Behaviour:
- Reset: out_valid=0, out_data=0, out_flags=0, both stage-valid bits 0. in_ready=1 in the first cycle after reset.
- Handshake:
  - Transfer occurs on a cycle with valid&&ready.
  - advance = !s2_valid || out_ready.
  - in_ready = advance (combinational). The whole pipe stalls when !advance.
  - out_data, out_flags and out_valid hold stable while out_valid && !out_ready.
- Latency: 2 cycles from accept to out_valid when there is no stall. Throughput is 1 word per cycle. Order is preserved and no word is dropped or duplicated.
- Stage 1 (unpack):
  - Register sign, e = exp32 - 127 + EXP_BIAS (signed, 10 bits), 24-bit significand with hidden 1, and class (zero, denormal32, inf, nan, normal).
  - Input denormals are treated as zero. They set underflow_to_zero if the fraction is nonzero.
- Stage 2 (round/pack):
  - Round to nearest, ties to even. The guard bit is the first dropped bit; sticky is the OR of the rest.
  - Normal case, 1 <= e <= MAX_EXP: man = frac[22:20] rounded. A rounding carry out of the mantissa gives man=0 and e+1.
  - Subnormal output, e <= 0: shift the significand right by 1-e (shift amounts of 26 or more produce all-zero bits plus sticky), then round into man with exp field 0. A result of 0 sets underflow_to_zero when the input was nonzero. Rounding up into 2^-14 gives exp=1, man=0.
  - Overflow: e > MAX_EXP, either before or after the rounding carry, saturates to {s,11110,111} and sets overflow_sat.
  - Inf gives {s,11111,000}. NaN gives canonical 9'h0FC (sign ignored). Zero gives {s,00000,000}.
  - inexact = guard|sticky, or forced on for sat/underflow. It is 0 for Inf, NaN and zero.
- rst asserted mid-stream discards both stages on the next edge; in-flight results are lost by design.
- Simultaneous out_ready and in_valid with a full pipe: both stages shift and no bubble is inserted.

Optional Feature:
- Macro FP9_CVT_STAT_EN.
- When defined:
  - Adds ports stat_clr (in, 1), sat_cnt (out, 16) and unf_cnt (out, 16).
  - Each counter increments by 1 on every output transfer (out_valid && out_ready) whose overflow_sat or underflow_to_zero flag, respectively, is set.
  - Counters saturate at 16'hFFFF and do not wrap.
  - stat_clr or rst zeroes the counters. If stat_clr and a counted transfer occur in the same cycle, the clear wins and the counter reads 0.
- When undefined: no extra ports and no counter logic.

Test Plan:
- Basic values with out_ready=1:
  - 0x3F800000 -> 9'h078, flags 0.
  - 0x3FC00000 -> 9'h07C.
  - The result appears exactly 2 cycles after accept.
- Ties to even:
  - 0x3F880000 -> 9'h078, inexact.
  - 0x3F980000 -> 9'h07A.
  - 0x3FF80000 -> carry to 9'h080.
- Saturation and specials:
  - 0x47700000 -> 9'h0F7, no flags.
  - 0x477C0000 -> 9'h0F7 with overflow_sat.
  - 0xFF800000 -> 9'h1F8.
  - 0x7FC00000 -> 9'h0FC.
- Underflow:
  - 0x37000000 -> 9'h001.
  - 0x36800000 -> 9'h000 with underflow_to_zero.
  - 0x00000001 (fp32 denormal) -> 9'h000 with underflow_to_zero.
- Backpressure: hold out_ready=0 for 5 cycles while offering 4 words.
  - Exactly 2 are accepted, then in_ready=0.
  - out_data is stable throughout the stall.
  - After release, all 4 words emerge in order with no loss.
- With FP9_CVT_STAT_EN defined:
  - 3 saturating transfers give sat_cnt=3.
  - stat_clr asserted coincident with a 4th saturating transfer leaves sat_cnt=0.
  - rst mid-stream drops out_valid to 0 on the next edge.

Source files
------------

// File: rtl/fp32_to_fp9_cvt_if.sv
// Stream bundle for the binary32 -> FP9 converter: input word side plus result side.
// The converter takes the slave modport and the producer/consumer takes the master modport.
interface fp32_to_fp9_cvt_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_data;
    logic [2:0]  out_flags;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/fp32_to_fp9_cvt.sv
// Two-stage binary32 -> FP9 (s/e5/m3) converter with RNE rounding and full backpressure.
// Optional saturation/underflow event counters are enabled with the FP9_CVT_STAT_EN macro.
module fp32_to_fp9_cvt #(
    parameter int unsigned EXP_BIAS = 15,
    parameter int unsigned MAX_EXP  = 30
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef FP9_CVT_STAT_EN
    input  logic                    stat_clr,
    output logic [15:0]             sat_cnt,
    output logic [15:0]             unf_cnt,
`endif
    fp32_to_fp9_cvt_if.slave        cvt
);
    typedef enum logic [2:0] {ClsZero, ClsDen, ClsInf, ClsNan, ClsNorm} cls_e;

    localparam logic signed [9:0] BiasAdj = $signed(10'(EXP_BIAS)) - 10'sd127;
    localparam logic signed [9:0] MaxExpS = $signed(10'(MAX_EXP));

    logic               w_advance;
    logic [7:0]         w_exp32;
    logic [22:0]        w_frac;
    cls_e               w_cls;

    logic               r_s1_valid;
    logic               r_s1_sign;
    logic signed [9:0]  r_s1_exp;
    logic [23:0]        r_s1_sig;
    cls_e               r_s1_cls;

    logic               r_out_valid;
    logic [8:0]         r_out_data;
    logic [2:0]         r_out_flags;

    logic signed [9:0]  w_sh;
    logic [48:0]        w_ext;
    logic               w_far;
    logic [2:0]         w_man;
    logic               w_guard;
    logic               w_sticky;
    logic               w_rnd;
    logic [3:0]         w_man_r;
    logic [8:0]         w_res;
    logic [2:0]         w_flags;

    assign w_advance     = !r_out_valid || cvt.out_ready;
    assign cvt.in_ready  = w_advance;
    assign cvt.out_valid = r_out_valid;
    assign cvt.out_data  = r_out_data;
    assign cvt.out_flags = r_out_flags;

    always_comb begin
        w_exp32 = cvt.in_data[30:23];
        w_frac  = cvt.in_data[22:0];
        if (w_exp32 == 8'h00) begin
            w_cls = (w_frac == 23'd0) ? ClsZero : ClsDen;
        end else if (w_exp32 == 8'hFF) begin
            w_cls = (w_frac == 23'd0) ? ClsInf : ClsNan;
        end else begin
            w_cls = ClsNorm;
        end
    end

    // Align so the kept mantissa sits at [48:46], guard at [45], sticky below.
    always_comb begin
        w_sh  = 10'sd1 - r_s1_exp;
        w_ext = '0;
        w_far = 1'b0;
        if (r_s1_exp >= 10'sd1) begin
            w_ext = {r_s1_sig[22:0], 26'd0};
        end else if (w_sh >= 10'sd26) begin
            w_far = 1'b1;
        end else begin
            w_ext = {r_s1_sig, 25'd0} >> (w_sh[4:0] - 5'd1);
        end
        w_man    = w_ext[48:46];
        w_guard  = w_ext[45];
        w_sticky = (|w_ext[44:0]) | w_far;
        w_rnd    = w_guard & (w_sticky | w_man[0]);
        w_man_r  = {1'b0, w_man} + {3'b000, w_rnd};
    end

    always_comb begin
        w_res   = '0;
        w_flags = '0;
        unique case (r_s1_cls)
            ClsZero: w_res = {r_s1_sign, 8'h00};
            ClsDen: begin
                w_res   = {r_s1_sign, 8'h00};
                w_flags = 3'b011;
            end
            ClsInf:  w_res = {r_s1_sign, 5'h1F, 3'b000};
            ClsNan:  w_res = 9'h0FC;
            ClsNorm: begin
                if (r_s1_exp > MaxExpS || (r_s1_exp == MaxExpS && w_man_r[3])) begin
                    w_res   = {r_s1_sign, 5'h1E, 3'h7};
                    w_flags = 3'b101;
                end else if (r_s1_exp >= 10'sd1) begin
                    w_flags[0] = w_guard | w_sticky;
                    if (w_man_r[3]) begin
                        w_res = {r_s1_sign, r_s1_exp[4:0] + 5'd1, 3'b000};
                    end else begin
                        w_res = {r_s1_sign, r_s1_exp[4:0], w_man_r[2:0]};
                    end
                end else if (w_man_r == 4'd0) begin
                    w_res   = {r_s1_sign, 8'h00};
                    w_flags = 3'b011;
                end else begin
                    w_flags[0] = w_guard | w_sticky;
                    // A carry out of a subnormal mantissa lands exactly on 2^-14.
                    if (w_man_r[3]) begin
                        w_res = {r_s1_sign, 5'd1, 3'b000};
                    end else begin
                        w_res = {r_s1_sign, 5'd0, w_man_r[2:0]};
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_exp    <= '0;
            r_s1_sig    <= '0;
            r_s1_cls    <= ClsZero;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_flags <= '0;
        end else if (w_advance) begin
            r_s1_valid <= cvt.in_valid;
            if (cvt.in_valid) begin
                r_s1_sign <= cvt.in_data[31];
                r_s1_exp  <= $signed({2'b00, w_exp32}) + BiasAdj;
                r_s1_sig  <= {1'b1, w_frac};
                r_s1_cls  <= w_cls;
            end
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data  <= w_res;
                r_out_flags <= w_flags;
            end
        end
    end

`ifdef FP9_CVT_STAT_EN
    logic        w_out_xfer;
    logic [15:0] r_sat_cnt;
    logic [15:0] r_unf_cnt;

    assign w_out_xfer = r_out_valid && cvt.out_ready;
    assign sat_cnt    = r_sat_cnt;
    assign unf_cnt    = r_unf_cnt;

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            r_sat_cnt <= '0;
            r_unf_cnt <= '0;
        end else if (w_out_xfer) begin
            if (r_out_flags[2] && r_sat_cnt != 16'hFFFF) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
            if (r_out_flags[1] && r_unf_cnt != 16'hFFFF) begin
                r_unf_cnt <= r_unf_cnt + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fp32_to_fp9_cvt.sv
// Directed self-checking bench for fp32_to_fp9_cvt; the counter checks compile in when
// FP9_CVT_STAT_EN is defined.
module tb_fp32_to_fp9_cvt;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

`ifdef FP9_CVT_STAT_EN
    logic        stat_clr = 1'b0;
    logic [15:0] sat_cnt;
    logic [15:0] unf_cnt;
`endif

    fp32_to_fp9_cvt_if u_if ();

    fp32_to_fp9_cvt u_dut (
        .clk      (clk),
        .rst      (rst),
`ifdef FP9_CVT_STAT_EN
        .stat_clr (stat_clr),
        .sat_cnt  (sat_cnt),
        .unf_cnt  (unf_cnt),
`endif
        .cvt      (u_if)
    );

    always #5 clk = ~clk;

    logic [31:0] bp_in  [4] = '{32'h3F800000, 32'h3FC00000, 32'h3F980000, 32'h47700000};
    logic [8:0]  bp_exp [4] = '{9'h078, 9'h07C, 9'h07A, 9'h0F7};
    logic [8:0]  got    [4];
    int          idx;
    int          nout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Accept one word, check the 2-cycle latency, then check result and flags.
    task automatic conv(input string tag, input logic [31:0] din, input logic [8:0] edata,
                        input logic [2:0] eflags);
        @(negedge clk);
        u_if.in_valid  = 1'b1;
        u_if.in_data   = din;
        u_if.out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, u_if.in_ready, 1);
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, u_if.out_valid, 0);
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, u_if.out_valid, 1);
        chk({tag, "_data"}, u_if.out_data, edata);
        chk({tag, "_flags"}, u_if.out_flags, eflags);
    endtask

    initial begin
        u_if.in_valid  = 1'b0;
        u_if.in_data   = '0;
        u_if.out_ready = 1'b0;

        do_reset();
        #1;
        chk("rst_out_valid", u_if.out_valid, 0);
        chk("rst_out_data", u_if.out_data, 0);
        chk("rst_out_flags", u_if.out_flags, 0);
        chk("rst_in_ready", u_if.in_ready, 1);

        conv("one",       32'h3F800000, 9'h078, 3'b000);
        conv("one_half",  32'h3FC00000, 9'h07C, 3'b000);
        conv("tie_even",  32'h3F880000, 9'h078, 3'b001);
        conv("tie_up",    32'h3F980000, 9'h07A, 3'b001);
        conv("carry",     32'h3FF80000, 9'h080, 3'b001);
        conv("max_fin",   32'h47700000, 9'h0F7, 3'b000);
        conv("sat",       32'h477C0000, 9'h0F7, 3'b101);
        conv("neg_inf",   32'hFF800000, 9'h1F8, 3'b000);
        conv("nan",       32'h7FC00000, 9'h0FC, 3'b000);
        conv("sub_min",   32'h37000000, 9'h001, 3'b000);
        conv("sub_zero",  32'h36800000, 9'h000, 3'b011);
        conv("den32",     32'h00000001, 9'h000, 3'b011);
        conv("neg_zero",  32'h80000000, 9'h100, 3'b000);

        // Backpressure: consumer stalls 5 cycles while 4 words are offered.
        do_reset();
        idx  = 0;
        nout = 0;
        for (int cyc = 0; cyc < 40 && nout < 4; cyc++) begin
            @(negedge clk);
            u_if.out_ready = (cyc >= 5);
            u_if.in_valid  = (idx < 4);
            if (idx < 4) u_if.in_data = bp_in[idx];
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                chk($sformatf("bp_hold_data_c%0d", cyc), u_if.out_data, 9'h078);
                chk($sformatf("bp_hold_valid_c%0d", cyc), u_if.out_valid, 1);
            end
            if (cyc == 4) begin
                chk("bp_accepted", idx, 2);
                chk("bp_in_ready_low", u_if.in_ready, 0);
            end
            if (u_if.out_valid && u_if.out_ready) begin
                got[nout] = u_if.out_data;
                nout++;
            end
            if (u_if.in_valid && u_if.in_ready) idx++;
        end
        u_if.in_valid = 1'b0;
        chk("bp_out_count", nout, 4);
        for (int i = 0; i < 4 && i < nout; i++) begin
            chk($sformatf("bp_out%0d", i), got[i], bp_exp[i]);
        end

`ifdef FP9_CVT_STAT_EN
        do_reset();
        #1;
        chk("stat_rst_sat", sat_cnt, 0);
        conv("stat_sat1", 32'h477C0000, 9'h0F7, 3'b101);
        conv("stat_sat2", 32'h477C0000, 9'h0F7, 3'b101);
        conv("stat_sat3", 32'h477C0000, 9'h0F7, 3'b101);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("stat_sat_cnt3", sat_cnt, 3);
        conv("stat_sat4", 32'h477C0000, 9'h0F7, 3'b101);
        @(negedge clk);
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        chk("stat_clr_wins", sat_cnt, 0);
        conv("stat_unf", 32'h36800000, 9'h000, 3'b011);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("stat_unf_cnt1", unf_cnt, 1);
        chk("stat_sat_after_unf", sat_cnt, 0);
`endif

        // Reset mid-stream discards in-flight results on the next edge.
        @(negedge clk);
        u_if.out_ready = 1'b0;
        u_if.in_valid  = 1'b1;
        u_if.in_data   = 32'h3F800000;
        @(posedge clk);
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        chk("mid_pre_valid", u_if.out_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", u_if.out_valid, 0);
        chk("mid_rst_ready", u_if.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
